// File: rtl/cdi_slave_bus_ctrl_pkg.sv
// cdi_slave_bus_ctrl_pkg: state encoding and default timing for the 68HC05 slave window sequencer.
package cdi_slave_pkg;
  typedef enum logic [2:0] {IDLE, DELAY, IRQ, WAIT_ACK, ACK, ERR, HOLD} slave_state_e;
  localparam int SLAVE_IRQ_DELAY = 20;
  localparam int SLAVE_IRQ_WIDTH = 1;
  localparam int SLAVE_TIMEOUT   = 4096;
endpackage

// File: rtl/cdi_slave_bus_ctrl_if.sv
// cdi_slave_bus_ctrl_if: CPU-side bus and 68HC05 port pins seen by the slave window sequencer.
interface cdi_slave_bus_ctrl_if;
  logic        cs;
  logic        as;
  logic        uds;
  logic        lds;
  logic        write_strobe;
  logic [6:0]  addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        bus_ack;
  logic        bus_err;
  logic        slave_irq;
  logic [1:0]  slave_addr;
  logic [7:0]  slave_wdata;
  logic        slave_rwn;
  logic [7:0]  slave_rdata;
  logic        slave_dtackn;
  logic        busy;
  modport master (
    output cs, as, uds, lds, write_strobe, addr, cpu_din, slave_rdata, slave_dtackn,
    input  cpu_dout, bus_ack, bus_err, slave_irq, slave_addr, slave_wdata, slave_rwn, busy
  );
  modport slave (
    input  cs, as, uds, lds, write_strobe, addr, cpu_din, slave_rdata, slave_dtackn,
    output cpu_dout, bus_ack, bus_err, slave_irq, slave_addr, slave_wdata, slave_rwn, busy
  );
endinterface

// File: rtl/cdi_slave_bus_ctrl.sv
// cdi_slave_bus_ctrl: sequences CPU accesses to the 68HC05 window (latch, delayed IRQ, DTACK wait, ack/err).
module cdi_slave_bus_ctrl
  import cdi_slave_pkg::*;
#(
  parameter int IRQ_DELAY = SLAVE_IRQ_DELAY,
  parameter int IRQ_WIDTH = SLAVE_IRQ_WIDTH,
  parameter int TIMEOUT   = SLAVE_TIMEOUT
) (
  input logic clk,
  input logic resetn,
  cdi_slave_bus_ctrl_if.slave bus
);
  slave_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] dout_q, dout_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rwn_q, rwn_d;
  logic        dtack_q;
  logic        start, abort, dtack_rise;
  assign start      = bus.cs && bus.as && (bus.uds || bus.lds);
  assign abort      = !bus.cs || !bus.as;
  assign dtack_rise = bus.slave_dtackn && !dtack_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
      wdata_q <= 8'hFF;
      rwn_q   <= 1'b1;
      dtack_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rwn_q   <= rwn_d;
      dtack_q <= bus.slave_dtackn;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rwn_d   = rwn_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = DELAY;
        cnt_d   = 8'(IRQ_DELAY - 1);
        addr_d  = bus.addr[1:0];
        rwn_d   = !bus.write_strobe;
        wdata_d = bus.lds ? bus.cpu_din[7:0] : bus.cpu_din[15:8];
      end
      DELAY: if (abort) state_d = IDLE;
        else if (cnt_q == 8'd0) begin
          state_d = IRQ;
          cnt_d   = 8'(IRQ_WIDTH - 1);
        end else cnt_d = cnt_q - 8'd1;
      IRQ: if (abort) state_d = IDLE;
        else if (cnt_q == 8'd0) begin
          state_d = WAIT_ACK;
          tcnt_d  = '0;
        end else cnt_d = cnt_q - 8'd1;
      // A DTACK edge wins over a timeout landing in the same cycle.
      WAIT_ACK: if (abort) state_d = IDLE;
        else if (dtack_rise) begin
          state_d = ACK;
          dout_d  = {bus.slave_rdata, bus.slave_rdata};
        end else if (tcnt_q == 16'(TIMEOUT - 1)) state_d = ERR;
        else tcnt_d = tcnt_q + 16'd1;
      ACK, ERR: state_d = HOLD;
      HOLD: if (abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.slave_irq   = state_q == IRQ;
    bus.bus_ack     = state_q == ACK && bus.cs;
    bus.bus_err     = state_q == ERR && bus.cs;
    bus.busy        = state_q != IDLE;
    bus.cpu_dout    = dout_q;
    bus.slave_addr  = addr_q;
    bus.slave_wdata = wdata_q;
    bus.slave_rwn   = rwn_q;
  end
endmodule

// File: tb/tb_cdi_slave_bus_ctrl.sv
// tb_cdi_slave_bus_ctrl: scoreboard bench; expected responses are queued at stimulus time and
// popped by a monitor whenever the DUT raises bus_ack or bus_err.
module tb_cdi_slave_bus_ctrl;
  localparam int DLY = 20;
  localparam int TMO = 4096;
  typedef struct {
    bit          is_err;
    logic [15:0] dout;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  int irq_first, irq_cnt, ack_c, ack_n, err_c, err_n, busy_mark;
  exp_t sb[$];
  cdi_slave_bus_ctrl_if bus();
  cdi_slave_bus_ctrl #(.IRQ_DELAY(DLY), .IRQ_WIDTH(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (resetn && (bus.bus_ack || bus.bus_err)) begin
      exp_t e;
      chk("ack_err_excl", 32'(bus.bus_ack & bus.bus_err), 0);
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_is_err", 32'(bus.bus_err), 32'(e.is_err));
        if (!e.is_err) chk("cpu_dout", 32'(bus.cpu_dout), 32'(e.dout));
      end
    end
  end
  task automatic idle_bus();
    bus.cs = 1'b0; bus.as = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0;
  endtask
  task automatic start_access(input logic wr, input logic u, input logic l,
                              input logic [6:0] a, input logic [15:0] din);
    @(negedge clk);
    bus.write_strobe = wr; bus.uds = u; bus.lds = l; bus.addr = a; bus.cpu_din = din;
    bus.cs = 1'b1; bus.as = 1'b1;
  endtask
  // Cycle c is the period after the c-th rising edge following the start; sample then drive.
  task automatic run_seq(input int rise_c, input int n, input int abort_c);
    irq_first = -1; irq_cnt = 0; ack_c = -1; ack_n = 0; err_c = -1; err_n = 0; busy_mark = -1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (bus.slave_irq) begin
        if (irq_first < 0) irq_first = c;
        irq_cnt++;
      end
      if (bus.bus_ack) begin
        if (ack_c < 0) ack_c = c;
        ack_n++;
      end
      if (bus.bus_err) begin
        if (err_c < 0) err_c = c;
        err_n++;
      end
      if (c == abort_c + 1) busy_mark = int'(bus.busy);
      if (rise_c >= 0 && c == rise_c - 5) bus.slave_dtackn = 1'b0;
      if (rise_c >= 0 && c == rise_c) bus.slave_dtackn = 1'b1;
      if (c == abort_c) bus.as = 1'b0;
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"}, 32'(bus.cpu_dout), 0);
    chk({tag, "_ack"}, 32'(bus.bus_ack), 0);
    chk({tag, "_err"}, 32'(bus.bus_err), 0);
    chk({tag, "_irq"}, 32'(bus.slave_irq), 0);
    chk({tag, "_saddr"}, 32'(bus.slave_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.slave_wdata), 32'hFF);
    chk({tag, "_rwn"}, 32'(bus.slave_rwn), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask
  initial begin
    idle_bus();
    bus.write_strobe = 1'b0; bus.addr = '0; bus.cpu_din = '0;
    bus.slave_rdata = 8'h00; bus.slave_dtackn = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    // Read with DTACK rising at cycle 30, strobes held afterwards.
    bus.slave_rdata = 8'h5A;
    sb.push_back('{is_err: 1'b0, dout: 16'h5A5A});
    start_access(1'b0, 1'b0, 1'b1, 7'h02, 16'h0000);
    run_seq(30, 41, -1);
    chk("rd_irq_first", irq_first, DLY);
    chk("rd_irq_cnt", irq_cnt, 1);
    chk("rd_ack_cycle", ack_c, 31);
    chk("rd_ack_cnt", ack_n, 1);
    chk("rd_err_cnt", err_n, 0);
    chk("rd_rwn", 32'(bus.slave_rwn), 1);
    chk("rd_saddr", 32'(bus.slave_addr), 2);
    chk("rd_hold_busy", 32'(bus.busy), 1);
    // Drop as for one cycle, then reassert for a second full access.
    bus.as = 1'b0;
    @(negedge clk);
    chk("b2b_idle_busy", 32'(bus.busy), 0);
    bus.slave_rdata = 8'hA5;
    sb.push_back('{is_err: 1'b0, dout: 16'hA5A5});
    bus.as = 1'b1;
    run_seq(30, 36, -1);
    chk("b2b_irq_first", irq_first, DLY);
    chk("b2b_ack_cycle", ack_c, 31);
    idle_bus();
    @(negedge clk);
    // Writes: uds selects the high byte, lds the low byte.
    start_access(1'b1, 1'b1, 1'b0, 7'h01, 16'h12AB);
    repeat (3) @(negedge clk);
    chk("wr_u_wdata", 32'(bus.slave_wdata), 32'h12);
    chk("wr_u_rwn", 32'(bus.slave_rwn), 0);
    chk("wr_u_saddr", 32'(bus.slave_addr), 1);
    idle_bus();
    @(negedge clk);
    chk("wr_u_abort_busy", 32'(bus.busy), 0);
    chk("wr_u_keep_wdata", 32'(bus.slave_wdata), 32'h12);
    start_access(1'b1, 1'b0, 1'b1, 7'h03, 16'h12AB);
    repeat (3) @(negedge clk);
    chk("wr_l_wdata", 32'(bus.slave_wdata), 32'hAB);
    chk("wr_l_saddr", 32'(bus.slave_addr), 3);
    idle_bus();
    @(negedge clk);
    // Timeout: DTACK held low for the whole access.
    bus.slave_dtackn = 1'b0;
    @(negedge clk);
    sb.push_back('{is_err: 1'b1, dout: 16'h0000});
    start_access(1'b0, 1'b0, 1'b1, 7'h00, 16'h0000);
    run_seq(-1, DLY + 1 + TMO + 4, -1);
    chk("tmo_irq_first", irq_first, DLY);
    chk("tmo_err_cycle", err_c, DLY + 1 + TMO);
    chk("tmo_err_cnt", err_n, 1);
    chk("tmo_ack_cnt", ack_n, 0);
    chk("tmo_hold_busy", 32'(bus.busy), 1);
    chk("tmo_dout_kept", 32'(bus.cpu_dout), 32'hA5A5);
    bus.as = 1'b0;
    @(negedge clk);
    chk("tmo_idle_busy", 32'(bus.busy), 0);
    idle_bus();
    bus.slave_dtackn = 1'b1;
    @(negedge clk);
    // Abort in DELAY at cycle 10, then a stray DTACK edge.
    start_access(1'b0, 1'b0, 1'b1, 7'h05, 16'h0000);
    run_seq(-1, 25, 10);
    chk("abt_busy_c11", busy_mark, 0);
    chk("abt_irq_cnt", irq_cnt, 0);
    chk("abt_ack_cnt", ack_n, 0);
    chk("abt_saddr_kept", 32'(bus.slave_addr), 1);
    bus.slave_dtackn = 1'b0;
    @(negedge clk);
    bus.slave_dtackn = 1'b1;
    begin
      int acc = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        acc += int'(bus.bus_ack) + int'(bus.busy);
      end
      chk("abt_late_dtack", acc, 0);
    end
    idle_bus();
    @(negedge clk);
    // Asynchronous reset while in IRQ.
    start_access(1'b0, 1'b0, 1'b1, 7'h02, 16'h0000);
    run_seq(-1, DLY + 1, -1);
    chk("rsti_irq_before", 32'(bus.slave_irq), 1);
    #2 resetn = 1'b0;
    #1;
    chk("rsti_irq_async", 32'(bus.slave_irq), 0);
    chk("rsti_busy_async", 32'(bus.busy), 0);
    idle_bus();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_reset_vals("rsti");
    bus.slave_rdata = 8'h3C;
    sb.push_back('{is_err: 1'b0, dout: 16'h3C3C});
    start_access(1'b0, 1'b0, 1'b1, 7'h02, 16'h0000);
    run_seq(30, 34, -1);
    chk("post_irq_first", irq_first, DLY);
    chk("post_ack_cycle", ack_c, 31);
    chk("post_saddr", 32'(bus.slave_addr), 2);
    idle_bus();
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
